// File: rtl/des_round_ctrl.sv
// Iterative DES Feistel round sequencer: holds L/R, folds f results, emits subkey index/shift.
// Optional round-wait watchdog enabled by defining DES_TIMEOUT_EN.
module des_round_ctrl #(
  parameter int ROUNDS  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] block_in,
  output logic        busy,
  output logic [31:0] r_out,
  output logic [3:0]  round_idx,
  output logic [3:0]  subkey_sel,
  output logic [1:0]  shift_amt,
  input  logic        f_valid,
  input  logic [31:0] f_in,
  output logic        out_valid,
  input  logic        out_ready,
`ifdef DES_TIMEOUT_EN
  output logic        error,
`endif
  output logic [63:0] block_out
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [3:0]  r_cnt;
  logic        r_dec;
  logic        w_last;
  logic        w_in_round;
  logic [3:0]  w_sub;
  logic        w_timeout;
  logic        w_err;

  assign w_last     = (r_cnt == 4'(ROUNDS - 1));
  assign w_in_round = (r_state == S_ROUND);
  assign w_sub      = r_dec ? (4'(ROUNDS - 1) - r_cnt) : r_cnt;

`ifdef DES_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait;
  logic          r_err;

  assign w_timeout = w_in_round && !f_valid && (r_wait == TW'(TIMEOUT - 1));
  assign w_err     = r_err;
  assign error     = r_err;

  // Wait counter clears on every f_valid; error latches on expiry until handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else if (w_in_round) begin
      if (f_valid || w_timeout) begin
        r_wait <= '0;
      end else begin
        r_wait <= r_wait + TW'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_ROUND;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ROUND: begin
        if ((f_valid && w_last) || w_timeout) begin
          w_next = S_DONE;
        end else begin
          w_next = S_ROUND;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Half registers, round counter and captured mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_l   <= 32'd0;
      r_r   <= 32'd0;
      r_cnt <= 4'd0;
      r_dec <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_l   <= block_in[63:32];
            r_r   <= block_in[31:0];
            r_dec <= decrypt;
            r_cnt <= 4'd0;
          end
        end
        S_ROUND: begin
          if (f_valid) begin
            r_l   <= r_r;
            r_r   <= r_l ^ f_in;
            r_cnt <= w_last ? 4'd0 : (r_cnt + 4'd1);
          end else if (w_timeout) begin
            r_cnt <= 4'd0;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign r_out      = r_r;
  assign round_idx  = w_in_round ? r_cnt : 4'd0;
  assign subkey_sel = w_in_round ? w_sub : 4'd0;
  // DES key schedule rotates by one bit only in rounds 1, 2, 9 and 16.
  assign shift_amt  = !w_in_round ? 2'd0 :
                      ((w_sub == 4'd0) || (w_sub == 4'd1) || (w_sub == 4'd8) || (w_sub == 4'd15)) ? 2'd1 : 2'd2;
  assign out_valid  = (r_state == S_DONE);
  assign block_out  = (out_valid && !w_err) ? {r_r, r_l} : 64'd0;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Self-checking bench for des_round_ctrl: Feistel model plus directed literal vectors.
module tb_des_round_ctrl;
  localparam int ROUNDS  = 16;
  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [63:0] block_in;
  logic        busy;
  logic [31:0] r_out;
  logic [3:0]  round_idx;
  logic [3:0]  subkey_sel;
  logic [1:0]  shift_amt;
  logic        f_valid;
  logic [31:0] f_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] block_out;
`ifdef DES_TIMEOUT_EN
  logic        error;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  des_round_ctrl #(.ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .block_in(block_in),
    .busy(busy), .r_out(r_out), .round_idx(round_idx), .subkey_sel(subkey_sel),
    .shift_amt(shift_amt), .f_valid(f_valid), .f_in(f_in), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef DES_TIMEOUT_EN
    .error(error),
`endif
    .block_out(block_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sched(input int idx);
    return (idx == 0 || idx == 1 || idx == 8 || idx == 15) ? 2'd1 : 2'd2;
  endfunction

  // Behavioural model: phase 0 idle, 1 rounds, 2 result held.
  int          m_ph;
  int          m_k;
  int          m_wait;
  logic [31:0] m_l;
  logic [31:0] m_r;
  logic        m_dec;
  logic        m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_k <= 0; m_wait <= 0; m_l <= 32'd0; m_r <= 32'd0; m_dec <= 1'b0; m_err <= 1'b0;
    end else if (m_ph == 0) begin
      if (start) begin
        m_l <= block_in[63:32]; m_r <= block_in[31:0]; m_dec <= decrypt; m_k <= 0; m_wait <= 0; m_ph <= 1;
      end
    end else if (m_ph == 1) begin
      if (f_valid) begin
        m_l <= m_r;
        m_r <= m_l ^ f_in;
        m_wait <= 0;
        if (m_k == ROUNDS - 1) begin m_k <= 0; m_ph <= 2; end
        else m_k <= m_k + 1;
      end
`ifdef DES_TIMEOUT_EN
      else if (m_wait == TIMEOUT - 1) begin
        m_ph <= 2; m_err <= 1'b1; m_k <= 0; m_wait <= 0;
      end else begin
        m_wait <= m_wait + 1;
      end
`endif
    end else begin
      if (out_ready) begin m_ph <= 0; m_err <= 1'b0; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      int sub;
      sub = (m_ph == 1) ? (m_dec ? ROUNDS - 1 - m_k : m_k) : 0;
      chk("busy", 64'(busy), 64'(m_ph != 0));
      chk("r_out", 64'(r_out), 64'(m_r));
      chk("round_idx", 64'(round_idx), (m_ph == 1) ? 64'(m_k) : 64'd0);
      chk("subkey_sel", 64'(subkey_sel), 64'(sub));
      chk("shift_amt", 64'(shift_amt), (m_ph == 1) ? 64'(sched(sub)) : 64'd0);
      chk("out_valid", 64'(out_valid), 64'(m_ph == 2));
      chk("block_out", block_out, (m_ph == 2 && !m_err) ? {m_r, m_l} : 64'd0);
`ifdef DES_TIMEOUT_EN
      chk("error", 64'(error), 64'(m_err));
`endif
    end
  end

  task automatic start_block(input logic dec, input logic [63:0] blk);
    @(posedge clk); #2;
    start = 1'b1; decrypt = dec; block_in = blk;
    @(posedge clk); #2;
    start = 1'b0; decrypt = ~dec; block_in = ~blk;
  endtask

  task automatic wait_ov(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
  endtask

  logic [1:0]  enc_shift [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
  int          cyc;
  logic [63:0] held;
  logic [31:0] r_before;

  initial begin
    rst = 1'b0; start = 1'b0; decrypt = 1'b0; block_in = 64'd0;
    f_valid = 1'b0; f_in = 32'd0; out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset r_out", 64'(r_out), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset block_out", block_out, 64'd0);
    chk("reset shift_amt", 64'(shift_amt), 64'd0);
    @(posedge clk); #2 rst = 1'b0;

    // Identity f: even round count restores halves, undone swap gives {R0,L0}.
    f_valid = 1'b1; f_in = 32'd0;
    start_block(1'b0, 64'h0123456789ABCDEF);
    wait_ov(cyc);
    chk("latency f=0", 64'(cyc), 64'd16);
    chk("result f=0", block_out, 64'h89ABCDEF01234567);
    @(posedge clk); #2;
    chk("accepted", 64'(out_valid), 64'd0);

    // All-ones f: 4-round period.
    f_in = 32'hFFFFFFFF;
    start_block(1'b0, 64'h0123456789ABCDEF);
    chk("r_out round0", 64'(r_out), 64'h89ABCDEF);
    @(posedge clk); #2;
    chk("r_out after round0", 64'(r_out), 64'hFEDCBA98);
    wait_ov(cyc);
    chk("latency f=1s", 64'(cyc), 64'd15);
    chk("result f=1s", block_out, 64'h89ABCDEF01234567);
    @(posedge clk); #2;

    // Encrypt then decrypt subkey/shift schedules.
    f_in = 32'h13579BDF;
    for (int d = 0; d < 2; d++) begin
      start_block(d[0], 64'hFEEDFACECAFEBEEF);
      for (int i = 0; i < 16; i++) begin
        chk("round_idx seq", 64'(round_idx), 64'(i));
        chk("subkey seq", 64'(subkey_sel), (d == 0) ? 64'(i) : 64'(15 - i));
        chk("shift seq", 64'(shift_amt), (d == 0) ? 64'(enc_shift[i]) : 64'(enc_shift[15 - i]));
        @(posedge clk); #2;
      end
      chk("done after 16", 64'(out_valid), 64'd1);
      @(posedge clk); #2;
    end

    // Stalls, held result and ignored starts.
    out_ready = 1'b0; f_valid = 1'b0;
    start_block(1'b0, 64'h1122334455667788);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      f_valid = cyc[0];
      f_in = 32'h01010101 * cyc;
      start = (cyc % 7 == 3);
      r_before = r_out;
      @(posedge clk); #2;
      if (!f_valid) chk("hold on stall", 64'(r_out), 64'(r_before));
      cyc++;
    end
    chk("stall finished", 64'(out_valid), 64'd1);
    start = 1'b0; f_valid = 1'b0;
    held = block_out;
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      @(posedge clk); #2;
      chk("block_out stable", block_out, held);
    end
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("start on handshake ignored", 64'(busy), 64'd0);

    // Async reset mid-block, then a clean block.
    f_valid = 1'b1; f_in = 32'h0BADF00D;
    start_block(1'b0, 64'hA5A5A5A55A5A5A5A);
    repeat (7) @(posedge clk);
    #2;
    chk("in round 7", 64'(round_idx), 64'd7);
    rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst r_out", 64'(r_out), 64'd0);
    chk("rst round_idx", 64'(round_idx), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #2 rst = 1'b0;
    f_in = 32'd0;
    start_block(1'b0, 64'h0123456789ABCDEF);
    wait_ov(cyc);
    chk("post-reset latency", 64'(cyc), 64'd16);
    chk("post-reset result", block_out, 64'h89ABCDEF01234567);
    @(posedge clk); #2;

`ifdef DES_TIMEOUT_EN
    f_valid = 1'b1;
    start_block(1'b0, 64'h0123456789ABCDEF);
    repeat (3) @(posedge clk);
    #2 f_valid = 1'b0;
    chk("stuck in round 3", 64'(round_idx), 64'd3);
    wait_ov(cyc);
    chk("timeout cycles", 64'(cyc), 64'd15);
    chk("timeout error", 64'(error), 64'd1);
    chk("timeout block_out", block_out, 64'd0);
    @(posedge clk); #2;
    chk("error cleared", 64'(error), 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
